// File: rtl/mult_pipe_hs.sv
// Elastic multiplier pipeline: STAGES valid/ready register stages carrying the
// operand mode alongside the payload, so a signed/unsigned switch never disturbs in-flight items.
module mult_pipe_hs #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic                           in_signed,
    input  logic [WIDTH-1:0]               multiplicand,
    input  logic [WIDTH-1:0]               multiplier,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [2*WIDTH-1:0]             product,
    output logic [$clog2(STAGES+1)-1:0]    occupancy,
    output logic                           busy
);

    localparam int PW = 2 * WIDTH;
    localparam int OW = $clog2(STAGES + 1);

    logic [STAGES-1:0] vld;
    logic [STAGES-1:0] mode;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [PW-1:0]     pay [STAGES];

    // Extending both operands to full width makes the low PW bits of the
    // product exact for both two's-complement and unsigned operands.
    function automatic logic [PW-1:0] mul(input logic [WIDTH-1:0] a,
                                          input logic [WIDTH-1:0] b,
                                          input logic             s);
        logic [PW-1:0] ax;
        logic [PW-1:0] bx;
        ax = s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
        bx = s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
        return ax * bx;
    endfunction

    // Ready ripples backwards: a stage may load when empty or when its own
    // content moves on in the same cycle.
    always_comb begin
        adv  = '0;
        load = '0;
        adv[STAGES-1] = vld[STAGES-1] & out_ready;
        for (int unsigned k = STAGES - 1; k >= 1; k--) begin
            load[k]   = ~vld[k] | adv[k];
            adv[k-1]  = vld[k-1] & load[k];
        end
        load[0]  = ~vld[0] | adv[0];
        in_ready = load[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld  <= '0;
            mode <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                pay[k] <= '0;
            end
        end else begin
            if (load[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    mode[0] <= in_signed;
                    pay[0]  <= (STAGES == 1) ? mul(multiplicand, multiplier, in_signed)
                                             : {multiplicand, multiplier};
                end
            end
            for (int unsigned k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        mode[k] <= mode[k-1];
                        pay[k]  <= (k == 1) ? mul(pay[0][PW-1:WIDTH], pay[0][WIDTH-1:0], mode[0])
                                            : pay[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            occupancy = occupancy + OW'(vld[k]);
        end
        busy      = |vld;
        out_valid = vld[STAGES-1];
        product   = pay[STAGES-1];
    end

endmodule

// File: tb/tb_mult_pipe_hs.sv
// Directed bench for mult_pipe_hs at 4x4/2 stages, plus 8x8/1 and 16x16/4
// instances driven with random handshake stalls.
module tb_mult_pipe_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int n_cmp = 0;
    int n_bad = 0;

    logic       iv0, ir0, sg0, ov0, or0, busy0;
    logic [3:0] a0, b0;
    logic [7:0] p0;
    logic [1:0] occ0;

    logic        iv1, ir1, sg1, ov1, or1, busy1;
    logic [7:0]  a1, b1;
    logic [15:0] p1;
    logic [0:0]  occ1;

    logic        iv2, ir2, sg2, ov2, or2, busy2;
    logic [15:0] a2, b2;
    logic [31:0] p2;
    logic [2:0]  occ2;

    mult_pipe_hs #(.WIDTH(4), .STAGES(2)) u_d0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .in_signed(sg0),
        .multiplicand(a0), .multiplier(b0), .out_valid(ov0), .out_ready(or0),
        .product(p0), .occupancy(occ0), .busy(busy0));

    mult_pipe_hs #(.WIDTH(8), .STAGES(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_signed(sg1),
        .multiplicand(a1), .multiplier(b1), .out_valid(ov1), .out_ready(or1),
        .product(p1), .occupancy(occ1), .busy(busy1));

    mult_pipe_hs #(.WIDTH(16), .STAGES(4)) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2), .in_signed(sg2),
        .multiplicand(a2), .multiplier(b2), .out_valid(ov2), .out_ready(or2),
        .product(p2), .occupancy(occ2), .busy(busy2));

    // Per-cycle snapshots taken on the falling edge, describing the cycle whose
    // rising edge has just been passed when the tick task returns.
    logic       s_ir, s_ov, s_fin, s_fout, s_busy;
    logic [7:0] s_p;
    logic [1:0] s_occ;
    logic        s1_ov, s1_fin, s1_fout;
    logic [15:0] s1_p;
    logic        s2_ov, s2_fin, s2_fout;
    logic [31:0] s2_p;

    task automatic tick0();
        @(negedge clk);
        s_ir = ir0; s_ov = ov0; s_p = p0; s_occ = occ0; s_busy = busy0;
        s_fin = iv0 && ir0; s_fout = ov0 && or0;
        @(posedge clk); #1;
    endtask

    task automatic tick1();
        @(negedge clk);
        s1_ov = ov1; s1_p = p1; s1_fin = iv1 && ir1; s1_fout = ov1 && or1;
        @(posedge clk); #1;
    endtask

    task automatic tick2();
        @(negedge clk);
        s2_ov = ov2; s2_p = p2; s2_fin = iv2 && ir2; s2_fout = ov2 && or2;
        @(posedge clk); #1;
    endtask

    // Integer reference: interpret operands as signed values when requested,
    // multiply in 64-bit arithmetic, keep the low 2*w bits.
    function automatic longint ref_mul(input longint a, input longint b, input bit s, input int w);
        longint sa, sb, m;
        sa = a; sb = b;
        if (s) begin
            if (sa >= (longint'(1) << (w - 1))) sa = sa - (longint'(1) << w);
            if (sb >= (longint'(1) << (w - 1))) sb = sb - (longint'(1) << w);
        end
        m = (longint'(1) << (2 * w)) - 1;
        return (sa * sb) & m;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        iv0 = 0; sg0 = 0; a0 = '0; b0 = '0; or0 = 0;
        iv1 = 0; sg1 = 0; a1 = '0; b1 = '0; or1 = 0;
        iv2 = 0; sg2 = 0; a2 = '0; b2 = '0; or2 = 0;
        #3;
        n_cmp++;
        if ({ov0, busy0, occ0, p0} !== 12'h000) begin
            n_bad++;
            $display("FAIL reset_d0: ov=%b busy=%b occ=%0d p=%h, want 0 0 0 00", ov0, busy0, occ0, p0);
        end
        n_cmp++;
        if ({ov1, busy1, occ1, p1, ov2, busy2, occ2, p2} !== '0) begin
            n_bad++;
            $display("FAIL reset_d12: ov1=%b p1=%h ov2=%b occ2=%0d p2=%h, want all 0", ov1, p1, ov2, occ2, p2);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({ir0, ir1, ir2} !== 3'b111) begin
            n_bad++;
            $display("FAIL ready_after_reset: in_ready=%b%b%b, want 111", ir0, ir1, ir2);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        or0 = 1; iv0 = 1; a0 = 4'd15; b0 = 4'd15; sg0 = 0;
        tick0();
        n_cmp++;
        if (s_fin !== 1'b1) begin
            n_bad++;
            $display("FAIL unsigned_accept: fire=%b, want 1", s_fin);
        end
        iv0 = 0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick0();
            if (s_ov === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++;
            $display("FAIL unsigned_latency: got %0d cycles, want 2", lat);
        end
        n_cmp++;
        if (s_p !== 8'hE1) begin
            n_bad++;
            $display("FAIL unsigned_15x15: product=%h, want e1", s_p);
        end
        tick0();
        n_cmp++;
        if ({s_occ, s_busy, s_ov} !== 4'b0000) begin
            n_bad++;
            $display("FAIL unsigned_drain: occ=%0d busy=%b ov=%b, want 0 0 0", s_occ, s_busy, s_ov);
        end
    endtask

    task automatic test_signed();
        logic [3:0] va [4];
        logic [3:0] vb [4];
        logic       vs [4];
        logic [7:0] ve [4];
        int ri;
        va = '{4'h8, 4'h8, 4'h8, 4'h8};
        vb = '{4'h8, 4'h7, 4'h8, 4'h7};
        vs = '{1'b1, 1'b1, 1'b0, 1'b0};
        ve = '{8'h40, 8'hC8, 8'h40, 8'h38};
        ri = 0;
        or0 = 1;
        for (int i = 0; i < 12 && ri < 4; i++) begin
            if (i < 4) begin
                iv0 = 1; a0 = va[i]; b0 = vb[i]; sg0 = vs[i];
            end else begin
                iv0 = 0; sg0 = ~sg0;
            end
            tick0();
            if (i < 4) begin
                n_cmp++;
                if (s_fin !== 1'b1) begin
                    n_bad++;
                    $display("FAIL signed_accept[%0d]: fire=%b, want 1", i, s_fin);
                end
            end
            if (s_fout === 1'b1) begin
                n_cmp++;
                if (s_p !== ve[ri]) begin
                    n_bad++;
                    $display("FAIL signed_result[%0d]: product=%h, want %h", ri, s_p, ve[ri]);
                end
                ri++;
            end
        end
        iv0 = 0;
        n_cmp++;
        if (ri != 4) begin
            n_bad++;
            $display("FAIL signed_count: got %0d results, want 4", ri);
        end
    endtask

    task automatic test_backpressure();
        or0 = 0;
        iv0 = 1; a0 = 4'd1; b0 = 4'd1; sg0 = 0;
        tick0();
        n_cmp++;
        if (s_fin !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_accept1: fire=%b, want 1", s_fin);
        end
        a0 = 4'd2; b0 = 4'd2;
        tick0();
        n_cmp++;
        if (s_fin !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_accept2: fire=%b, want 1", s_fin);
        end
        a0 = 4'd3; b0 = 4'd3;
        for (int h = 0; h < 3; h++) begin
            tick0();
            n_cmp++;
            if ({s_ir, s_occ, s_ov, s_p} !== {1'b0, 2'd2, 1'b1, 8'h01}) begin
                n_bad++;
                $display("FAIL bp_full[%0d]: in_ready=%b occ=%0d ov=%b p=%h, want 0 2 1 01", h, s_ir, s_occ, s_ov, s_p);
            end
        end
        or0 = 1;
        tick0();
        n_cmp++;
        if ({s_ir, s_fin, s_fout, s_p} !== {1'b1, 1'b1, 1'b1, 8'h01}) begin
            n_bad++;
            $display("FAIL bp_release: in_ready=%b fire_in=%b fire_out=%b p=%h, want 1 1 1 01", s_ir, s_fin, s_fout, s_p);
        end
        iv0 = 0;
        tick0();
        n_cmp++;
        if ({s_fout, s_p} !== {1'b1, 8'h04}) begin
            n_bad++;
            $display("FAIL bp_second: fire_out=%b p=%h, want 1 04", s_fout, s_p);
        end
        tick0();
        n_cmp++;
        if ({s_fout, s_p} !== {1'b1, 8'h09}) begin
            n_bad++;
            $display("FAIL bp_third: fire_out=%b p=%h, want 1 09", s_fout, s_p);
        end
        tick0();
        n_cmp++;
        if ({s_ov, s_occ} !== 3'b000) begin
            n_bad++;
            $display("FAIL bp_empty: ov=%b occ=%0d, want 0 0", s_ov, s_occ);
        end
    endtask

    task automatic test_streaming();
        longint q[$];
        longint e;
        int sent, rcv;
        logic [3:0] ca, cb;
        logic       cs;
        sent = 0; rcv = 0;
        or0 = 1;
        for (int c = 0; c < 200 && rcv < 100; c++) begin
            if (sent < 100) begin
                ca = 4'($urandom); cb = 4'($urandom); cs = 1'($urandom_range(0, 1));
                iv0 = 1; a0 = ca; b0 = cb; sg0 = cs;
            end else begin
                iv0 = 0;
            end
            tick0();
            if (c >= 2 && c < 100) begin
                n_cmp++;
                if ({s_occ, s_ov, s_fin} !== {2'd2, 1'b1, 1'b1}) begin
                    n_bad++;
                    $display("FAIL stream_steady[%0d]: occ=%0d ov=%b fire_in=%b, want 2 1 1", c, s_occ, s_ov, s_fin);
                end
            end
            if (s_fout === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stream_extra: product=%h with nothing outstanding", s_p);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (longint'(s_p) != e) begin
                        n_bad++;
                        $display("FAIL stream_result[%0d]: product=%h, want %h", rcv, s_p, e);
                    end
                end
                rcv++;
            end
            if (s_fin === 1'b1) begin
                q.push_back(ref_mul(longint'(ca), longint'(cb), cs, 4));
                sent++;
            end
        end
        iv0 = 0;
        n_cmp++;
        if (rcv != 100 || q.size() != 0) begin
            n_bad++;
            $display("FAIL stream_count: received %0d, outstanding %0d, want 100 and 0", rcv, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        or0 = 0;
        iv0 = 1; a0 = 4'd3; b0 = 4'd5; sg0 = 0;
        tick0();
        a0 = 4'd2; b0 = 4'd7;
        tick0();
        iv0 = 0;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({ov0, occ0, p0, busy0} !== 12'h000) begin
            n_bad++;
            $display("FAIL midreset_clear: ov=%b occ=%0d p=%h busy=%b, want 0 0 00 0", ov0, occ0, p0, busy0);
        end
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        or0 = 1;
        for (int c = 0; c < 6; c++) begin
            tick0();
            n_cmp++;
            if ({s_ov, s_ir} !== 2'b01) begin
                n_bad++;
                $display("FAIL midreset_ghost[%0d]: ov=%b in_ready=%b, want 0 1", c, s_ov, s_ir);
            end
        end
    endtask

    task automatic test_sweep_w8();
        logic [7:0]  da [4];
        logic [7:0]  db [4];
        logic        ds [4];
        logic [15:0] de [4];
        longint q[$];
        longint e, ce;
        logic [7:0]  ca, cb;
        logic        cs, need, hold;
        logic [15:0] hp;
        int sent, rcv, lat;
        da = '{8'hFF, 8'h80, 8'h80, 8'hFF};
        db = '{8'hFF, 8'h80, 8'h7F, 8'h01};
        ds = '{1'b0, 1'b1, 1'b1, 1'b1};
        de = '{16'hFE01, 16'h4000, 16'hC080, 16'hFFFF};

        or1 = 1; iv1 = 1; a1 = 8'h0C; b1 = 8'h0D; sg1 = 0;
        tick1();
        iv1 = 0;
        lat = 0;
        for (int c = 1; c <= 10; c++) begin
            tick1();
            if (s1_ov === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if (lat != 1 || s1_p !== 16'h009C) begin
            n_bad++;
            $display("FAIL w8_latency: latency=%0d product=%h, want 1 009c", lat, s1_p);
        end

        sent = 0; rcv = 0; need = 1; hold = 0; hp = '0;
        ca = '0; cb = '0; cs = 0; ce = 0;
        for (int c = 0; c < 800 && rcv < 44; c++) begin
            if (need && sent < 44) begin
                if (sent < 4) begin
                    ca = da[sent]; cb = db[sent]; cs = ds[sent]; ce = longint'(de[sent]);
                end else begin
                    ca = 8'($urandom); cb = 8'($urandom); cs = 1'($urandom_range(0, 1));
                    ce = ref_mul(longint'(ca), longint'(cb), cs, 8);
                end
                need = 0;
            end
            iv1 = (sent < 44) && ($urandom_range(0, 3) != 0);
            a1 = ca; b1 = cb; sg1 = cs;
            or1 = ($urandom_range(0, 3) != 0);
            tick1();
            if (hold) begin
                n_cmp++;
                if (s1_ov !== 1'b1 || s1_p !== hp) begin
                    n_bad++;
                    $display("FAIL w8_stall_hold: ov=%b p=%h, want 1 %h", s1_ov, s1_p, hp);
                end
            end
            hold = s1_ov && !s1_fout;
            hp = s1_p;
            if (s1_fout === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL w8_extra: product=%h with nothing outstanding", s1_p);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (longint'(s1_p) != e) begin
                        n_bad++;
                        $display("FAIL w8_result[%0d]: product=%h, want %h", rcv, s1_p, e);
                    end
                end
                rcv++;
            end
            if (s1_fin === 1'b1) begin
                q.push_back(ce);
                sent++;
                need = 1;
            end
        end
        iv1 = 0;
        n_cmp++;
        if (rcv != 44 || q.size() != 0) begin
            n_bad++;
            $display("FAIL w8_count: received %0d, outstanding %0d, want 44 and 0", rcv, q.size());
        end
    endtask

    task automatic test_sweep_w16();
        logic [15:0] da [4];
        logic [15:0] db [4];
        logic        ds [4];
        logic [31:0] de [4];
        longint q[$];
        longint e, ce;
        logic [15:0] ca, cb;
        logic        cs, need, hold;
        logic [31:0] hp;
        int sent, rcv, lat;
        da = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h1234};
        db = '{16'hFFFF, 16'h8000, 16'h0002, 16'h0010};
        ds = '{1'b0, 1'b1, 1'b1, 1'b0};
        de = '{32'hFFFE0001, 32'h40000000, 32'hFFFFFFFE, 32'h00012340};

        or2 = 1; iv2 = 1; a2 = 16'h0100; b2 = 16'h0100; sg2 = 0;
        tick2();
        iv2 = 0;
        lat = 0;
        for (int c = 1; c <= 12; c++) begin
            tick2();
            if (s2_ov === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if (lat != 4 || s2_p !== 32'h00010000) begin
            n_bad++;
            $display("FAIL w16_latency: latency=%0d product=%h, want 4 00010000", lat, s2_p);
        end

        sent = 0; rcv = 0; need = 1; hold = 0; hp = '0;
        ca = '0; cb = '0; cs = 0; ce = 0;
        for (int c = 0; c < 800 && rcv < 44; c++) begin
            if (need && sent < 44) begin
                if (sent < 4) begin
                    ca = da[sent]; cb = db[sent]; cs = ds[sent]; ce = longint'(de[sent]);
                end else begin
                    ca = 16'($urandom); cb = 16'($urandom); cs = 1'($urandom_range(0, 1));
                    ce = ref_mul(longint'(ca), longint'(cb), cs, 16);
                end
                need = 0;
            end
            iv2 = (sent < 44) && ($urandom_range(0, 3) != 0);
            a2 = ca; b2 = cb; sg2 = cs;
            or2 = ($urandom_range(0, 3) != 0);
            tick2();
            if (hold) begin
                n_cmp++;
                if (s2_ov !== 1'b1 || s2_p !== hp) begin
                    n_bad++;
                    $display("FAIL w16_stall_hold: ov=%b p=%h, want 1 %h", s2_ov, s2_p, hp);
                end
            end
            hold = s2_ov && !s2_fout;
            hp = s2_p;
            if (s2_fout === 1'b1) begin
                if (q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL w16_extra: product=%h with nothing outstanding", s2_p);
                end else begin
                    e = q.pop_front();
                    n_cmp++;
                    if (longint'(s2_p) != e) begin
                        n_bad++;
                        $display("FAIL w16_result[%0d]: product=%h, want %h", rcv, s2_p, e);
                    end
                end
                rcv++;
            end
            if (s2_fin === 1'b1) begin
                q.push_back(ce);
                sent++;
                need = 1;
            end
        end
        iv2 = 0;
        n_cmp++;
        if (rcv != 44 || q.size() != 0) begin
            n_bad++;
            $display("FAIL w16_count: received %0d, outstanding %0d, want 44 and 0", rcv, q.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_backpressure();
        test_streaming();
        test_reset_midflight();
        test_sweep_w8();
        test_sweep_w16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult_pipe_hs.md
MULT_PIPE_HS -- requirements
Module: mult_pipe_hs

Interface
REQ-001 SHALL provide parameters, one per line: name, default, meaning.
- WIDTH  4  operand width in bits, legal 2..64
- STAGES  2  pipeline register stages, legal 1..8
REQ-002 SHALL provide ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  operand pair offered
- in_ready  out  1  block can accept operand pair
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled with operands
- multiplicand  in  WIDTH  operand A
- multiplier  in  WIDTH  operand B
- out_valid  out  1  product available
- out_ready  in  1  consumer takes product
- product  out  2*WIDTH  full-precision A*B
- occupancy  out  $clog2(STAGES+1)  number of valid stages in flight
- busy  out  1  occupancy != 0

Function
REQ-003 SHALL transfer an input when in_valid && in_ready on a rising clk edge, and an output when out_valid && out_ready.
REQ-004 SHALL implement STAGES register stages, each holding a valid bit, the mode bit and payload; stage 1 holds the registered operands, stage STAGES drives out_valid/product (registered output, no combinational path from inputs to product).
REQ-005 When STAGES=1, the single stage SHALL hold the computed product directly.
REQ-006 Product SHALL be exact: unsigned mode = zero-extended A*B; signed mode = sign-extended A*B in two's complement, 2*WIDTH bits, no truncation or saturation.
REQ-007 Mode SHALL travel with its operands; changing in_signed between transfers SHALL NOT affect in-flight items.
REQ-008 Stage k SHALL load from stage k-1 when stage k is empty or stage k is itself transferring onward in the same cycle (bubble collapse); otherwise it holds.
REQ-009 in_ready SHALL equal !stage1_valid || stage1_advances (combinational from out_ready permitted); no input accepted while in_ready=0.
REQ-010 Unstalled latency SHALL be exactly STAGES cycles: transfer at edge t -> out_valid=1 with correct product after edge t+STAGES.
REQ-011 Unstalled throughput SHALL be one result per cycle.
REQ-012 While out_valid && !out_ready, product and out_valid SHALL remain stable; no item is dropped or duplicated.
REQ-013 Results SHALL emerge in acceptance order.
REQ-014 occupancy SHALL increment on input-only transfer, decrement on output-only transfer, and stay unchanged on simultaneous input+output transfer; SHALL never exceed STAGES nor go below 0.
REQ-015 With all stages full and out_ready=0, in_ready SHALL be 0; asserting out_ready SHALL allow a new input in the same cycle (full-pipe pass-through).
REQ-016 Payload registers of a non-loading stage SHALL not change.

Reset
REQ-017 rst_n low SHALL immediately (asynchronously) clear all stage valid bits, payloads and mode bits to 0; out_valid=0, product=0, occupancy=0, busy=0.
REQ-018 in_ready SHALL be 1 after reset release (empty pipe).
REQ-019 Reset mid-operation SHALL discard all in-flight items; none emerge after release.
REQ-020 Synchronous deassertion of rst_n relative to clk is the integrator's responsibility.

Verification
REQ-021 Bench SHALL cover, at WIDTH=4, STAGES=2:
- Unsigned: A=15, B=15, mode 0, out_ready=1 -> product=0xE1 (225), out_valid exactly 2 cycles after accept.
- Signed: A=0x8, B=0x8, mode 1 -> product=0x40 (+64); A=0x8, B=0x7, mode 1 -> 0xC8 (-56); same operands mode 0 -> 0x40 and 0x38.
- Backpressure: 3 back-to-back inputs 1*1, 2*2, 3*3, out_ready=0 -> in_ready falls after 2 accepts, occupancy=2, product holds 0x01; release out_ready -> 0x01, 0x04, 0x09 in order, third input accepted on release cycle.
- Streaming: 100 random inputs with in_valid=1, out_ready=1 -> one result per cycle, all match reference model, occupancy constant 2 in steady state.
- Reset mid-flight: 2 items in pipe, pull rst_n low between edges -> out_valid, occupancy, product drop to 0 immediately; no result appears after release.
- Parameter sweep: WIDTH=8/STAGES=1 and WIDTH=16/STAGES=4 with random handshake stalls -> results exact, ordered, latency equals STAGES when unstalled.
